// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial-SRAM emulator (READ 0x03 / WRITE 0x02, 24-bit address, sequential) over a local byte memory.
// Latency: pin-to-decode SYNC_STAGES+1 clk; read fetch-to-MISO SYNC_STAGES+2 clk, hidden by the >=8x clk:spi_clk ratio.
// Backpressure: none; the SPI initiator paces everything and the local memory must accept a strobe every clk.
// Ports: clk/rst (sync, active high); spi_clk/spi_cs_n/spi_mosi in, spi_miso/spi_miso_oe out;
//        mem_addr/mem_rd/mem_rdata/mem_wr/mem_wdata to the local memory; busy = transaction open.
module spi_sram_responder #(
    parameter int MEM_AW      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_d, cs_d;
    // Walks a 1 through after reset; edges are only trusted once the
    // synchronisers and the edge-detect flops hold real pin samples, so a
    // cs_n held low through reset does not look like a fresh select.
    logic [SYNC_STAGES:0]   settle_sr;

    logic [2:0]  bit_cnt;
    logic [1:0]  addr_cnt;
    logic [6:0]  shreg;
    logic [15:0] addr_hi;     // first two address bytes; third arrives with rx_byte
    logic        is_rd;
    logic        rd_cap;      // mem_rdata is valid this clk
    logic        tx_load;     // next fall starts a new byte from txbuf
    logic [7:0]  txbuf;
    logic [7:0]  txshift;

    logic sclk_s, cs_n_s, mosi_s, settled;
    logic rise, fall, cs_fall, byte_done;
    logic [7:0] rx_byte;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_n_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign settled   = settle_sr[SYNC_STAGES];
    assign rise      = settled & ~cs_n_s & sclk_s & ~sclk_d;
    assign fall      = settled & ~cs_n_s & ~sclk_s & sclk_d;
    assign cs_fall   = settled & cs_d & ~cs_n_s;
    assign byte_done = rise & (bit_cnt == 3'd7);
    assign rx_byte   = {shreg, mosi_s};
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            settle_sr <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_n_s;
            settle_sr <= {settle_sr[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (cs_n_s) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cs_fall) state_n = ST_CMD;
                ST_CMD: begin
                    if (byte_done) begin
                        if (rx_byte == 8'h03 || rx_byte == 8'h02) begin
                            state_n = ST_ADDR;
                        end else begin
                            state_n = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR: begin
                    if (byte_done && addr_cnt == 2'd2) begin
                        state_n = is_rd ? ST_READ : ST_WRITE;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            addr_cnt    <= '0;
            shreg       <= '0;
            addr_hi     <= '0;
            is_rd       <= 1'b0;
            rd_cap      <= 1'b0;
            tx_load     <= 1'b0;
            txbuf       <= '0;
            txshift     <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_addr    <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            rd_cap <= mem_rd & ~cs_n_s;

            // Sequential-mode post-increment, one clk after each access.
            if (mem_wr) begin
                mem_addr <= mem_addr + MEM_AW'(1);
            end
            if (rd_cap) begin
                txbuf    <= mem_rdata;
                tx_load  <= 1'b1;
                mem_addr <= mem_addr + MEM_AW'(1);
            end

            if (cs_n_s) begin
                // Deselect: drop any partial byte and release the pad.
                bit_cnt     <= '0;
                addr_cnt    <= '0;
                tx_load     <= 1'b0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                if (rise && state != ST_IDLE) begin
                    shreg   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end

                case (state)
                    ST_CMD: begin
                        if (byte_done) begin
                            is_rd    <= (rx_byte == 8'h03);
                            addr_cnt <= '0;
                        end
                    end
                    ST_ADDR: begin
                        if (byte_done) begin
                            addr_hi  <= {addr_hi[7:0], rx_byte};
                            addr_cnt <= addr_cnt + 2'd1;
                            if (addr_cnt == 2'd2) begin
                                // Upper address bits beyond MEM_AW are dropped here.
                                mem_addr <= MEM_AW'({addr_hi, rx_byte});
                                mem_rd   <= is_rd;
                            end
                        end
                    end
                    ST_READ: begin
                        // Prefetch the next byte as soon as the current one completes.
                        if (byte_done) begin
                            mem_rd <= 1'b1;
                        end
                        if (fall) begin
                            spi_miso_oe <= 1'b1;
                            if (tx_load) begin
                                spi_miso <= txbuf[7];
                                txshift  <= {txbuf[6:0], 1'b0};
                                tx_load  <= 1'b0;
                            end else begin
                                spi_miso <= txshift[7];
                                txshift  <= {txshift[6:0], 1'b0};
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (byte_done) begin
                            mem_wdata <= rx_byte;
                            mem_wr    <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: bit-banged SPI mode-0 initiator plus a synchronous byte memory.
// Latency: memory returns read data one clk after mem_rd, matching the responder's expectation.
// Backpressure: none; SPI half period is HALF clk, well above the 8x ratio floor.
module tb_spi_sram_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk, spi_cs_n, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_rdata, mem_wdata;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:65535];
    int          rd_cnt = 0, wr_cnt = 0, oe_cnt = 0, both_cnt = 0;
    logic [23:0] wr_log [$];

    always #5 clk = ~clk;

    spi_sram_responder #(.MEM_AW(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_clk     (spi_clk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .busy        (busy)
    );

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_wr) begin
            wr_cnt <= wr_cnt + 1;
            wr_log.push_back({mem_addr, mem_wdata});
        end
        if (mem_rd && mem_wr) both_cnt <= both_cnt + 1;
        if (spi_miso_oe) oe_cnt <= oe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            wait_clk(HALF);
            rx[i] = spi_miso;
            spi_clk = 1'b1;
            wait_clk(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic cs_lo();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_hi();
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a);
        logic [7:0] dummy;
        spi_byte(cmd, dummy);
        spi_byte(a[23:16], dummy);
        spi_byte(a[15:8], dummy);
        spi_byte(a[7:0], dummy);
    endtask

    initial begin
        logic [7:0] rx0, rx1, dummy;
        int rd0, wr0, oe0;

        mem[16'h1234] = 8'hA5;
        mem[16'h1235] = 8'h5A;
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;

        // 1: reset with pins toggling
        rst = 1'b1; spi_cs_n = 1'b0; spi_clk = 1'b0; spi_mosi = 1'b1;
        @(negedge clk); spi_clk = 1'b1; spi_mosi = 1'b0;
        @(negedge clk); spi_clk = 1'b0;
        chk("rst_miso", spi_miso, 0);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        spi_cs_n = 1'b1;
        rst = 1'b0;
        wait_clk(10);

        // 2: WRITE 02 00 12 34, data A5 5A
        cs_lo();
        send_hdr(8'h02, 24'h001234);
        chk("wr_busy", busy, 1);
        spi_byte(8'hA5, dummy);
        spi_byte(8'h5A, dummy);
        cs_hi();
        chk("wr_count", wr_cnt, 2);
        chk("wr0", wr_log[0], 24'h1234A5);
        chk("wr1", wr_log[1], 24'h12355A);
        chk("wr_idle_busy", busy, 0);

        // 3: READ 03 00 12 34, two data bytes
        rd0 = rd_cnt;
        cs_lo();
        send_hdr(8'h03, 24'h001234);
        spi_byte(8'h00, rx0);
        spi_byte(8'h00, rx1);
        chk("rd_oe", spi_miso_oe, 1);
        cs_hi();
        chk("rd_byte0", rx0, 8'hA5);
        chk("rd_byte1", rx1, 8'h5A);
        chk("rd_strobes", rd_cnt - rd0, 3);
        chk("rd_oe_release", spi_miso_oe, 0);

        // 4: READ with upper address bits set, wrapping FFFF -> 0000
        cs_lo();
        send_hdr(8'h03, 24'hABFFFF);
        spi_byte(8'h00, rx0);
        spi_byte(8'h00, rx1);
        cs_hi();
        chk("wrap_byte0", rx0, 8'h11);
        chk("wrap_byte1", rx1, 8'h22);

        // 5: unknown command ignored until deselect
        rd0 = rd_cnt; wr0 = wr_cnt; oe0 = oe_cnt;
        cs_lo();
        send_hdr(8'h9F, 24'h123456);
        spi_byte(8'h78, dummy);
        chk("ign_busy", busy, 1);
        cs_hi();
        chk("ign_rd", rd_cnt - rd0, 0);
        chk("ign_wr", wr_cnt - wr0, 0);
        chk("ign_oe", oe_cnt - oe0, 0);
        chk("ign_idle", busy, 0);
        cs_lo();
        send_hdr(8'h03, 24'h001235);
        spi_byte(8'h00, rx0);
        cs_hi();
        chk("after_ign_rd", rx0, 8'h5A);

        // 6a: WRITE aborted after 3 data bits
        wr0 = wr_cnt;
        cs_lo();
        send_hdr(8'h02, 24'h000010);
        spi_bits(8'hFF, 3, dummy);
        cs_hi();
        chk("abort_wr", wr_cnt - wr0, 0);
        chk("abort_busy", busy, 0);

        // 6b: reset pulse mid-READ, cs_n kept low
        cs_lo();
        send_hdr(8'h03, 24'h001234);
        spi_byte(8'h00, rx0);
        chk("mid_rd_byte", rx0, 8'hA5);
        chk("mid_rd_oe", spi_miso_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_oe", spi_miso_oe, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_miso", spi_miso, 0);
        rst = 1'b0;
        rd0 = rd_cnt;
        spi_byte(8'h03, dummy);
        chk("no_resume_busy", busy, 0);
        chk("no_resume_rd", rd_cnt - rd0, 0);
        cs_hi();
        cs_lo();
        send_hdr(8'h03, 24'h001234);
        spi_byte(8'h00, rx0);
        cs_hi();
        chk("post_rst_rd", rx0, 8'hA5);

        chk("rd_wr_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
